// File: rtl/int_mul_seq.sv
// Sequential shift-add integer multiplier for MUL / MULH / MULHSU / MULHU.
// Latency: WIDTH CALC cycles + FIX + DONE, so o_valid rises WIDTH+2 edges after accept.
// Backpressure: the result is held in DONE until i_ready; o_ready is low in CALC and FIX.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     request handshake (accept on i_valid && o_ready)
//   i_op                  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_a, i_b              rs1, rs2 operands
//   o_valid / i_ready     result handshake (taken on o_valid && i_ready)
//   o_result              selected half of the signed/unsigned product
//
// Optional feature: define INT_MUL_SEQ_EARLY_EXIT_EN to leave CALC as soon as
// the remaining multiplier bits are all zero (minimum one CALC cycle).
module int_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           op_q;
    logic                 sign_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        cnt_q;

    logic                 accept;
    logic                 calc_last;
    logic                 a_signed;
    logic                 b_signed;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 prod_sign;
    logic [2*WIDTH-1:0]   acc_fix;
    logic [WIDTH-1:0]     fix_result;

    // Operand conditioning. The most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    always_comb begin
        a_signed  = (i_op != 2'b11);
        b_signed  = ~i_op[1];
        neg_a     = a_signed & i_a[WIDTH-1];
        neg_b     = b_signed & i_b[WIDTH-1];
        mag_a     = neg_a ? (~i_a + WIDTH'(1)) : i_a;
        mag_b     = neg_b ? (~i_b + WIDTH'(1)) : i_b;
        // A zero magnitude forces a positive sign so a zero product never
        // gets negated into something other than zero.
        prod_sign = (neg_a ^ neg_b) && (mag_a != '0) && (mag_b != '0);
    end

`ifdef INT_MUL_SEQ_EARLY_EXIT_EN
    // Stop once the multiplier is about to shift to zero; the counter bound
    // still caps the loop at WIDTH cycles.
    assign calc_last = (cnt_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign calc_last = (cnt_q == CW'(WIDTH - 1));
`endif

    // Sign fix-up and half selection for the FIX cycle.
    always_comb begin
        acc_fix    = sign_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        fix_result = (op_q == 2'b00) ? acc_fix[WIDTH-1:0] : acc_fix[2*WIDTH-1:WIDTH];
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                // Taking the result frees the unit in the same cycle, so a
                // new request can be accepted without an IDLE bubble.
                o_ready = i_ready;
                if (i_ready) begin
                    state_d = i_valid ? CALC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        accept = i_valid && o_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            o_result <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= i_op;
                sign_q   <= prod_sign;
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                mplier_q <= mag_b;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    CALC: begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                    FIX: begin
                        o_result <= fix_result;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_mul_seq.sv
// Randomized scoreboard bench for int_mul_seq (WIDTH=32).
// The driver pushes the expected result and expected o_valid edge on accept;
// the monitor checks results, latency, hold-while-stalled and reset outputs.
module tb_int_mul_seq;

    localparam int W = 32;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_op;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;

    int_mul_seq #(.WIDTH(W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    typedef struct {
        logic [W-1:0] res;
        int           vld_edge;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_mode = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference: full-precision product with operands extended per op.
    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic         as;
        logic         bs;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        as = (op != 2'b11);
        bs = (op == 2'b00) || (op == 2'b01);
        ea = {{(128-W){as & a[W-1]}}, a};
        eb = {{(128-W){bs & b[W-1]}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    function automatic int calc_cycles(input logic [1:0] op, input logic [W-1:0] b);
`ifdef INT_MUL_SEQ_EARLY_EXIT_EN
        logic [W-1:0] m;
        int           n;
        m = (!op[1] && b[W-1]) ? (~b + 1) : b;
        n = 1;
        for (int i = 0; i < W; i++) begin
            if (m[i]) n = i + 1;
        end
        return n;
`else
        return W + (op == 2'b00 ? 0 : 0) + (b == b ? 0 : 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge sees.
    logic         rst_pend = 1'b0;
    logic         vprev = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] hold_res = '0;
    int           rise_edge = 0;

    always @(negedge i_clk) begin
        if (rst_pend) begin
            chk("rst_o_valid", 64'(o_valid), 64'd0);
            chk("rst_o_result", 64'(o_result), 64'd0);
            chk("rst_o_ready", 64'(o_ready), 64'd1);
        end
        rst_pend = i_rst;
        if (i_rst) begin
            exp_q.delete();
            vprev = 1'b0;
            hold  = 1'b0;
        end else begin
            if (o_valid && !vprev) rise_edge = cyc + 1;
            if (hold) begin
                chk("hold_o_valid", 64'(o_valid), 64'd1);
                chk("hold_o_result", 64'(o_result), 64'(hold_res));
            end
            if (o_valid && !i_ready) begin
                chk("stall_o_ready", 64'(o_ready), 64'd0);
            end
            if (o_valid && i_ready) begin
                chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("o_result", 64'(o_result), 64'(e.res));
                    chk("o_valid_edge", 64'(rise_edge), 64'(e.vld_edge));
                end
            end
            hold     = o_valid && !i_ready;
            hold_res = o_result;
            vprev    = o_valid;
        end
    end

    // Present a request until accepted; called and returns just after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        int e;
        exp_t x;
        got = 0;
        e   = 0;
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge i_clk);
            if (o_ready) begin
                got = 1;
                e   = cyc + 1;
            end
            @(posedge i_clk);
            #1;
            if (!got && rand_mode) i_ready = ($urandom_range(0, 3) != 0);
        end
        if (!got) begin
            $display("FAIL accept_timeout: o_ready never rose for op=%0d", op);
            $fatal(1, "bench stopped");
        end
        x.res      = ref_res(op, a, b);
        x.vld_edge = e + calc_cycles(op, b) + 2;
        exp_q.push_back(x);
        // Scramble inputs after accept; the unit must ignore them.
        i_valid = 1'b0;
        i_op    = 2'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
            if (rand_mode) i_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_op    = 2'b00;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Directed corner operands, issued back to back.
        issue(2'b00, 32'd7, 32'd6);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b00, 32'd5, 32'd3);
        issue(2'b00, 32'd12345, 32'd0);
        issue(2'b01, 32'd0, 32'h8000_0000);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b00, 32'hFFFF_FFFB, 32'd3);

        // Stall in DONE for 5 cycles, then take the result and issue together.
        idle(W + 4);
        i_ready = 1'b0;
        issue(2'b01, 32'hFFFF_FFF9, 32'd13);
        for (int n = 0; n < 200 && !o_valid; n++) @(posedge i_clk);
        if (!o_valid) begin
            $display("FAIL stall_wait: o_valid never rose");
            $fatal(1, "bench stopped");
        end
        repeat (5) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        issue(2'b10, 32'h8000_0001, 32'h7FFF_FFFF);

        // Reset while the counter is at 10; the pending result must never appear.
        issue(2'b00, 32'd123, 32'd456);
        repeat (10) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle(W + 10);

        // Random traffic with random consumer backpressure.
        rand_mode = 1;
        for (int t = 0; t < 60; t++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            idle($urandom_range(0, 3));
        end

        rand_mode = 0;
        i_ready   = 1'b1;
        for (int n = 0; n < 200 && (exp_q.size() != 0 || o_valid); n++) @(posedge i_clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout: %0d results never delivered", exp_q.size());
            $fatal(1, "bench stopped");
        end
        repeat (2) @(posedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/int_mul_seq.md
INT_MUL_SEQ -- requirements
Module: int_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width, legal range 8..64.
REQ-002 SHALL have port i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  request accepted when i_valid && o_ready at a rising edge.
REQ-006 SHALL have port i_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have ports i_a, i_b  input  WIDTH each  operands: i_a is rs1, i_b is rs2.
REQ-008 SHALL have port o_valid  output  1  result valid, held until taken.
REQ-009 SHALL have port i_ready  input  1  consumer takes result when o_valid && i_ready at a rising edge.
REQ-010 SHALL have port o_result  output  WIDTH  result.
REQ-011 SHALL use one clock with synchronous, active-high reset, as fixed above.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-013 SHALL drive o_ready as (state==IDLE) || (state==DONE && i_ready); o_ready SHALL be low in CALC and FIX.
REQ-014 SHALL latch i_op, |i_a|, |i_b| and the product sign on accept, then go to CALC; input changes after accept SHALL be ignored.
REQ-015 SHALL determine operand signedness by op. MUL: a and b signed (low half is sign-independent). MULH: a and b signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
REQ-016 SHALL set the magnitude of a signed operand to its two's-complement absolute value held in WIDTH unsigned bits; 2^(WIDTH-1) SHALL be representable.
REQ-017 SHALL run the CALC datapath as follows: 2*WIDTH accumulator cleared on accept; 2*WIDTH multiplicand shifted left 1 per cycle; multiplier shifted right 1 per cycle; accumulator += multiplicand when multiplier LSB is 1.
REQ-018 SHALL spend exactly WIDTH cycles in CALC (counter 0..WIDTH-1), then go to FIX, unless REQ-029 applies.
REQ-019 SHALL, in FIX, negate the 2*WIDTH accumulator when the product sign is 1, select the low half for MUL and the high half otherwise, register it into o_result, and go to DONE.
REQ-020 SHALL assert o_valid exactly in DONE; with macro off, o_valid SHALL rise WIDTH+2 cycles after the accept edge.
REQ-021 SHALL hold o_result and o_valid stable in DONE while i_ready is low.
REQ-022 SHALL handle the DONE exit conditions as follows. i_ready && !i_valid: go to IDLE, o_valid drops. i_ready && i_valid: new request accepted in the same cycle, go to CALC (back-to-back, no IDLE bubble).
REQ-023 SHALL set the product sign to 0 when either magnitude is 0, so the result is exactly 0.
REQ-024 SHALL hold o_result at its last value outside DONE; it is don't-care when o_valid is low, but SHALL NOT be X.

Reset
REQ-025 SHALL, while i_rst is high at a clock edge, set state=IDLE, o_valid=0, o_result=0, counter=0 and all datapath registers to 0.
REQ-026 SHALL, on reset in CALC, FIX or DONE, discard the operation; no o_valid SHALL follow.
REQ-027 SHALL keep o_ready at 1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL use macro INT_MUL_SEQ_EARLY_EXIT_EN.
REQ-029 SHALL, when INT_MUL_SEQ_EARLY_EXIT_EN is defined, leave CALC for FIX after the cycle in which the shifted multiplier becomes 0 (minimum 1 CALC cycle). CALC cycles SHALL equal max(1, position of highest set bit of |b| + 1). The result SHALL be identical to the macro-off result.
REQ-030 SHALL, when INT_MUL_SEQ_EARLY_EXIT_EN is undefined, always spend WIDTH CALC cycles, with no early-exit logic present.

Verification (WIDTH=32, i_ready=1 unless noted)
REQ-031 SHALL cover MUL: a=7, b=6 -> o_result=42; macro off, o_valid at accept+34.
REQ-032 SHALL cover MULH: a=b=0x80000000 -> o_result=0x40000000. Also MULH a=b=0xFFFFFFFF -> o_result=0x00000000.
REQ-033 SHALL cover MULHSU and MULHU, both with a=b=0xFFFFFFFF. MULHSU -> o_result=0xFFFFFFFF. MULHU -> o_result=0xFFFFFFFE.
REQ-034 SHALL cover back-pressure and back-to-back. Hold i_ready=0 for 5 DONE cycles: o_valid and o_result stay stable, o_ready=0. Raising i_ready together with a new i_valid accepts it that cycle; the next result is correct.
REQ-035 SHALL cover reset mid-CALC: assert i_rst at CALC count 10 -> next cycle state IDLE, o_valid=0, o_result=0, o_ready=1, no stale result.
REQ-036 SHALL cover early exit with the macro defined. MUL a=5, b=3 -> 2 CALC cycles, o_valid at accept+4, o_result=15. MUL b=0 -> 1 CALC cycle, o_result=0.
